// File: rtl/csa_operand_feeder.sv
// Packs a serial term stream into groups of five for the 5:2 CSA stage.
// A0..A2 launch one cycle before B0/B1; a {valid,tag,cnt} sideband is delayed to line up with the CSA result.
module csa_operand_feeder #(
  parameter int DATA_W  = 26,
  parameter int TAG_W   = 4,
  parameter int CSA_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              flush,
  output logic [DATA_W-1:0] A0,
  output logic [DATA_W-1:0] A1,
  output logic [DATA_W-1:0] A2,
  output logic [DATA_W-1:0] B0,
  output logic [DATA_W-1:0] B1,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [2:0]        res_cnt
);

  localparam int STAGES = CSA_LAT;

  logic [4:0][DATA_W-1:0]  slots, slots_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic [TAG_W-1:0]        tag;
  logic [1:0][DATA_W-1:0]  skew;
  logic                    acc, launch;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][TAG_W-1:0]  tag_pipe;
  logic [STAGES:0][2:0]        cnt_pipe;

  assign in_ready = ~rst;
  assign acc      = in_valid & in_ready;

  // Same-cycle accept is folded in before the launch decision, so flush sees it.
  always_comb begin
    slots_nxt = slots;
    cnt_nxt   = cnt;
    if (acc) begin
      slots_nxt[cnt] = in_data;
      cnt_nxt        = cnt + 3'd1;
    end
  end

  assign launch = (acc & ((cnt == 3'd4) | in_last)) | (flush & (cnt_nxt != 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      slots    <= '0;
      cnt      <= '0;
      tag      <= '0;
      skew     <= '0;
      A0       <= '0;
      A1       <= '0;
      A2       <= '0;
      B0       <= '0;
      B1       <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      cnt_pipe <= '0;
    end else begin
      A0   <= launch ? slots_nxt[0] : '0;
      A1   <= launch ? slots_nxt[1] : '0;
      A2   <= launch ? slots_nxt[2] : '0;
      // Skew register holds the B half for one cycle to match the CSA's internal stagger.
      skew <= launch ? {slots_nxt[4], slots_nxt[3]} : '0;
      B0   <= skew[0];
      B1   <= skew[1];
      if (launch) begin
        slots <= '0;
        cnt   <= '0;
        tag   <= tag + 1'b1;
      end else begin
        slots <= slots_nxt;
        cnt   <= cnt_nxt;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], launch};
      tag_pipe <= {tag_pipe[STAGES-1:0], tag};
      cnt_pipe <= {cnt_pipe[STAGES-1:0], cnt_nxt};
    end
  end

  assign res_valid = vld_pipe[STAGES];
  assign res_tag   = tag_pipe[STAGES];
  assign res_cnt   = cnt_pipe[STAGES];

endmodule

// File: tb/tb_csa_operand_feeder.sv
// Directed bench for csa_operand_feeder; a tiny CSA model sums A (two cycles back) and B (one cycle back).
module tb_csa_operand_feeder;
  localparam int DW = 26;
  localparam int TW = 4;

  logic          clk = 0;
  logic          rst, in_valid, in_ready, in_last, flush;
  logic [DW-1:0] in_data;
  logic [DW-1:0] A0, A1, A2, B0, B1;
  logic          res_valid;
  logic [TW-1:0] res_tag;
  logic [2:0]    res_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] sa1 = '0, sa2 = '0, sb1 = '0;

  csa_operand_feeder #(.DATA_W(DW), .TAG_W(TW), .CSA_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush), .A0(A0), .A1(A1), .A2(A2), .B0(B0), .B1(B1),
    .res_valid(res_valid), .res_tag(res_tag), .res_cnt(res_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records this cycle's A/B sums for the CSA model, then moves to 1ns after the next edge.
  task automatic tick();
    sa2 = sa1;
    sa1 = A0 + A1 + A2;
    sb1 = B0 + B1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] csa_sum();
    return sa2 + sb1;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l; flush = 0;
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic idle();
    in_valid = 0; in_last = 0; flush = 0;
    tick();
  endtask

  task automatic do_flush();
    in_valid = 0; flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1; in_valid = 0; in_last = 0; flush = 0; in_data = '0;
    for (int i = 0; i < n; i++) tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_last = 0; flush = 0; in_data = '0;
    // Test 1: reset state then a full group 1..5
    tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_A0", A0, 0);
    chk("rst_B1", B1, 0);
    chk("rst_rv", res_valid, 0);
    tick(); tick();
    rst = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    for (int i = 1; i <= 5; i++) send(DW'(i), 0);
    chk("t1_A0", A0, 1); chk("t1_A1", A1, 2); chk("t1_A2", A2, 3);
    chk("t1_B0_early", B0, 0);
    idle();
    chk("t1_B0", B0, 4); chk("t1_B1", B1, 5); chk("t1_A0_clr", A0, 0);
    chk("t1_rv_early", res_valid, 0);
    idle();
    chk("t1_rv", res_valid, 1); chk("t1_tag", res_tag, 0); chk("t1_cnt", res_cnt, 5);
    chk("t1_sum", csa_sum(), 15);
    chk("t1_B0_clr", B0, 0);

    // Test 2: partial group closed by in_last
    send(7, 0); send(9, 1);
    chk("t2_A0", A0, 7); chk("t2_A1", A1, 9); chk("t2_A2", A2, 0);
    idle();
    chk("t2_B0", B0, 0); chk("t2_B1", B1, 0);
    idle();
    chk("t2_rv", res_valid, 1); chk("t2_tag", res_tag, 1); chk("t2_cnt", res_cnt, 2);
    chk("t2_sum", csa_sum(), 16);
    idle();
    chk("t2_rv_drop", res_valid, 0);

    // Test 3: ten all-ones terms, modular wrap of the sum
    do_reset(1);
    for (int c = 1; c <= 13; c++) begin
      if (c <= 10) send(26'h3FFFFFF, 0); else idle();
      chk("t3_rv", res_valid, (c == 7 || c == 12) ? 1 : 0);
      if (c == 5 || c == 10) chk("t3_A2", A2, 26'h3FFFFFF);
      if (c == 7)  begin chk("t3_tag0", res_tag, 0); chk("t3_sum0", csa_sum(), 26'h3FFFFFB); end
      if (c == 12) begin chk("t3_tag1", res_tag, 1); chk("t3_sum1", csa_sum(), 26'h3FFFFFB); end
    end

    // Test 4: back-to-back single-term launches
    do_reset(1);
    send(1, 1);
    chk("t4_A0a", A0, 1); chk("t4_A1a", A1, 0);
    send(2, 1);
    chk("t4_A0b", A0, 2);
    send(3, 1);
    chk("t4_A0c", A0, 3);
    chk("t4_rv0", res_valid, 1); chk("t4_tag0", res_tag, 0); chk("t4_cnt0", res_cnt, 1);
    idle();
    chk("t4_A0_clr", A0, 0);
    chk("t4_rv1", res_valid, 1); chk("t4_tag1", res_tag, 1); chk("t4_cnt1", res_cnt, 1);
    idle();
    chk("t4_rv2", res_valid, 1); chk("t4_tag2", res_tag, 2); chk("t4_sum2", csa_sum(), 3);
    idle();
    chk("t4_rv_end", res_valid, 0);

    // Test 5: flush with a partial group, then flush with nothing pending
    do_reset(1);
    send(5, 0); send(6, 0);
    do_flush();
    chk("t5_A0", A0, 5); chk("t5_A1", A1, 6); chk("t5_A2", A2, 0);
    do_flush();
    chk("t5_A0_empty", A0, 0);
    idle();
    chk("t5_rv", res_valid, 1); chk("t5_cnt", res_cnt, 2); chk("t5_tag", res_tag, 0);
    chk("t5_sum", csa_sum(), 11);
    idle();
    chk("t5_rv_empty", res_valid, 0);
    idle();
    chk("t5_rv_empty2", res_valid, 0);

    // Test 6: reset mid-group discards the partial group
    do_reset(1);
    send(100, 0); send(200, 0); send(300, 0);
    rst = 1;
    #1;
    chk("t6_ready_rst", in_ready, 0);
    tick();
    rst = 0;
    for (int i = 10; i <= 14; i++) begin
      send(DW'(i), 0);
      chk("t6_rv_quiet", res_valid, 0);
    end
    chk("t6_A0", A0, 10); chk("t6_A2", A2, 12);
    idle();
    chk("t6_rv_quiet2", res_valid, 0);
    idle();
    chk("t6_rv", res_valid, 1); chk("t6_tag", res_tag, 0); chk("t6_cnt", res_cnt, 5);
    chk("t6_sum", csa_sum(), 60);

    // Test 7: seventeen back-to-back groups, tag wraps 15 -> 0
    do_reset(1);
    for (int c = 1; c <= 20; c++) begin
      if (c <= 17) send(DW'(c), 1); else idle();
      chk("t7_rv", res_valid, (c >= 3 && c <= 19) ? 1 : 0);
      if (c >= 3 && c <= 19) begin
        chk("t7_tag", res_tag, (c - 3) % 16);
        chk("t7_cnt", res_cnt, 1);
        chk("t7_sum", csa_sum(), c - 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
